// File: rtl/wb_mem_responder.sv
// Single-port 32-bit strobe/acknowledge memory slave with programmable wait states and abort.
// Define MEM_ERR_EN to answer out-of-range addresses with an err_o pulse instead of wrapping.
module wb_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [1:0]        sel_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef MEM_ERR_EN
  typedef enum logic [1:0] {IDLE, WAIT, ACK, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
`endif

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] lat_adr;
  logic              lat_we;
  logic [1:0]        lat_sel;
  logic [31:0]       lat_dat;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              wait_done;
  logic              finish;
  logic [ADDR_W-1:0] req_adr;
  logic              req_we;
  logic [1:0]        req_sel;
  logic [31:0]       req_dat;
  logic              req_oor;
  logic [IDX_W-1:0]  req_idx;

  // With zero wait states the request completes on the accepting edge, so the
  // live bus inputs are used there; otherwise the latched copies are.
  assign accept    = (state == IDLE) && cyc_i && stb_i;
  assign wait_done = (state == WAIT) && cyc_i && (wait_cnt == 4'd1);
  assign finish    = (accept && (WAIT_STATES == 0)) || wait_done;

  assign req_adr = (state == IDLE) ? adr_i : lat_adr;
  assign req_we  = (state == IDLE) ? we_i  : lat_we;
  assign req_sel = (state == IDLE) ? sel_i : lat_sel;
  assign req_dat = (state == IDLE) ? dat_i : lat_dat;
  assign req_idx = IDX_W'(32'(req_adr) % DEPTH);

`ifdef MEM_ERR_EN
  logic lat_oor;
  assign req_oor = (state == IDLE) ? (32'(adr_i) >= DEPTH) : lat_oor;
`else
  assign req_oor = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign busy_o = (state != IDLE);

  // Storage is deliberately not reset; rst_n gating stops a write slipping in during reset.
  always_ff @(posedge clk) begin
    if (rst_n && finish && !req_oor && req_we) begin
      if (req_sel[0]) mem[req_idx][15:0]  <= req_dat[15:0];
      if (req_sel[1]) mem[req_idx][31:16] <= req_dat[31:16];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      ack_o    <= 1'b0;
      dat_o    <= 32'h0;
      lat_adr  <= '0;
      lat_we   <= 1'b0;
      lat_sel  <= 2'b00;
      lat_dat  <= 32'h0;
`ifdef MEM_ERR_EN
      lat_oor  <= 1'b0;
      err_o    <= 1'b0;
`endif
    end else begin
      ack_o <= 1'b0;
`ifdef MEM_ERR_EN
      err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            lat_adr  <= adr_i;
            lat_we   <= we_i;
            lat_sel  <= sel_i;
            lat_dat  <= dat_i;
            wait_cnt <= 4'(WAIT_STATES);
`ifdef MEM_ERR_EN
            lat_oor  <= (32'(adr_i) >= DEPTH);
`endif
            if (WAIT_STATES != 0) state <= WAIT;
          end
        end
        WAIT: begin
          if (!cyc_i) state <= IDLE;
          else if (wait_cnt != 4'd1) wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase

      // Completion overrides the state chosen above.
      if (finish) begin
`ifdef MEM_ERR_EN
        if (req_oor) begin
          state <= ERR;
          err_o <= 1'b1;
        end else
`endif
        begin
          state <= ACK;
          ack_o <= 1'b1;
          if (!req_we) dat_o <= mem[req_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench: two responders (0 wait states / DEPTH 200, 3 wait states / DEPTH 256)
// compared against a word-array reference model; follows MEM_ERR_EN when defined.
module tb_wb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [7:0]  adr [2];
  logic [1:0]  sel [2];
  logic [31:0] dat [2];
  logic [31:0] dout [2];
  logic        ack [2];
  logic        err [2];
  logic        busy [2];

  int checks;
  int errors;

  logic [31:0] mm [2][256];
  logic [31:0] model_dat [2];

  wb_mem_responder #(.ADDR_W(8), .DEPTH(200), .WAIT_STATES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .adr_i(adr[0]), .sel_i(sel[0]), .dat_i(dat[0]), .dat_o(dout[0]),
    .ack_o(ack[0]), .err_o(err[0]), .busy_o(busy[0])
  );

  wb_mem_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .adr_i(adr[1]), .sel_i(sel[1]), .dat_i(dat[1]), .dat_o(dout[1]),
    .ack_o(ack[1]), .err_o(err[1]), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int depth_of(input int inst);
    return (inst == 0) ? 200 : 256;
  endfunction

  function automatic int latency_of(input int inst);
    return (inst == 0) ? 1 : 4;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance inst, checked against the model.
  task automatic apply_stimulus(input int inst, input logic w, input logic [7:0] a,
                                input logic [1:0] s, input logic [31:0] d);
    int          n;
    logic        got;
    logic        exp_err;
    int          idx;
    logic [31:0] mask;
    @(negedge clk);
    cyc[inst] = 1'b1; stb[inst] = 1'b1; we[inst] = w;
    adr[inst] = a; sel[inst] = s; dat[inst] = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      got = ack[inst] | err[inst];
      if (!got && n < latency_of(inst)) check_output("busy_wait", 32'(busy[inst]), 32'd1);
    end
    cyc[inst] = 1'b0; stb[inst] = 1'b0;
`ifdef MEM_ERR_EN
    exp_err = (int'(a) >= depth_of(inst));
`else
    exp_err = 1'b0;
`endif
    idx = int'(a) % depth_of(inst);
    if (!exp_err) begin
      if (w) begin
        mask = {{16{s[1]}}, {16{s[0]}}};
        mm[inst][idx] = (mm[inst][idx] & ~mask) | (d & mask);
      end else begin
        model_dat[inst] = mm[inst][idx];
      end
    end
    check_output("latency", 32'(n), 32'(latency_of(inst)));
    check_output("ack", 32'(ack[inst]), 32'(!exp_err));
    check_output("err", 32'(err[inst]), 32'(exp_err));
    check_output("busy_done", 32'(busy[inst]), 32'd1);
    check_output("dat_o", dout[inst], model_dat[inst]);
    @(posedge clk); #1;
    check_output("ack_pulse", 32'(ack[inst] | err[inst]), 32'd0);
    check_output("idle", 32'(busy[inst]), 32'd0);
  endtask

  initial begin
    logic [7:0] ra;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      adr[i] = 8'h0; sel[i] = 2'b00; dat[i] = 32'h0;
      model_dat[i] = 32'h0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check_output("rst_ack", 32'(ack[i]), 32'd0);
      check_output("rst_err", 32'(err[i]), 32'd0);
      check_output("rst_busy", 32'(busy[i]), 32'd0);
      check_output("rst_dat", dout[i], 32'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) apply_stimulus(0, 1'b1, 8'(i), 2'b11, $urandom);

    $display("[TB] zero-wait write/read");
    apply_stimulus(0, 1'b1, 8'h10, 2'b11, 32'hDEADBEEF);
    apply_stimulus(0, 1'b0, 8'h10, 2'b01, 32'h0);
    check_output("deadbeef", dout[0], 32'hDEADBEEF);

    $display("[TB] halfword merge");
    apply_stimulus(0, 1'b1, 8'h20, 2'b11, 32'h11112222);
    apply_stimulus(0, 1'b1, 8'h20, 2'b10, 32'hAAAA0000);
    apply_stimulus(0, 1'b1, 8'h20, 2'b01, 32'h0000BBBB);
    apply_stimulus(0, 1'b1, 8'h20, 2'b00, 32'h55555555);
    apply_stimulus(0, 1'b0, 8'h20, 2'b11, 32'h0);
    check_output("merge", dout[0], 32'hAAAABBBB);

    $display("[TB] out-of-range address");
    apply_stimulus(0, 1'b0, 8'hD0, 2'b11, 32'h0);

    $display("[TB] back-to-back reads");
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 8'h10; sel[0] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_output("b2b_ack", 32'(ack[0]), 32'((i % 2) == 0));
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    model_dat[0] = mm[0][16];
    check_output("b2b_dat", dout[0], model_dat[0]);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(0, 255));
      apply_stimulus(0, 1'($urandom), ra, 2'($urandom), $urandom);
    end

    $display("[TB] wait states and abort");
    apply_stimulus(1, 1'b1, 8'h30, 2'b11, 32'h0);
    apply_stimulus(1, 1'b0, 8'h30, 2'b11, 32'h0);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h30; sel[1] = 2'b11;
    dat[1] = 32'h12345678;
    repeat (2) begin
      @(posedge clk); #1;
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_output("abort_ack", 32'(ack[1]), 32'd0);
    end
    check_output("abort_idle", 32'(busy[1]), 32'd0);
    apply_stimulus(1, 1'b0, 8'h30, 2'b11, 32'h0);

    $display("[TB] reset during wait");
    apply_stimulus(1, 1'b1, 8'h40, 2'b11, 32'hCAFEF00D);
    apply_stimulus(1, 1'b0, 8'h40, 2'b11, 32'h0);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 8'h40; sel[1] = 2'b11;
    dat[1] = 32'h0BADBEEF;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_ack", 32'(ack[1]), 32'd0);
    check_output("mid_rst_busy", 32'(busy[1]), 32'd0);
    check_output("mid_rst_dat", dout[1], 32'h0);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    model_dat[0] = 32'h0;
    model_dat[1] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1, 1'b0, 8'h40, 2'b11, 32'h0);
    check_output("rst_keep", dout[1], 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
